// File: rtl/alu_decode.sv
// alu_decode: decodes the RV integer register/immediate ALU instructions plus
// LUI/AUIPC into an ALU operand bundle. The bundle is decoded combinationally
// at the input and held in a two-entry buffer (main + skid). The main entry
// drives the outputs. in_ready is a pure flop output, so the upstream
// handshake never sees a combinational path from out_ready.
module alu_decode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [2:0]      op,
    output logic            sub,
    output logic            sra,
    output logic [4:0]      rd,
    output logic            wen,
    output logic            illegal
);

    // Only the two base widths are meaningful; anything else is a build error.
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("alu_decode: XLEN must be 32 or 64");
    end

    // Shift-amount width: 5 bits on RV32, 6 bits on RV64.
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    // Major opcodes handled here.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 values that carry extra encoding rules.
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    // funct7 values legal on register-register ops.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One decoded instruction, as presented to the ALU and writeback.
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      op;
        logic            sub;
        logic            sra;
        logic [4:0]      rd;
        logic            wen;
        logic            illegal;
    } bundle_t;

    // ------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd_f;
    logic signed [11:0] i_imm;
    logic signed [31:0] u_imm;
    logic [XLEN-1:0]   i_imm_ext;
    logic [XLEN-1:0]   u_imm_ext;
    logic [XLEN-1:0]   shamt_ext;
    logic              shift_hi_zero;
    logic              unused_rs1_idx;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd_f   = instr[11:7];

    // Register indices are resolved by the register file upstream; only the
    // read values arrive here.
    assign unused_rs1_idx = ^instr[19:15];

    // I-type and U-type immediates, sign-extended to the datapath width.
    assign i_imm     = $signed(instr[31:20]);
    assign u_imm     = $signed({instr[31:12], 12'b0});
    assign i_imm_ext = XLEN'(i_imm);
    assign u_imm_ext = XLEN'(u_imm);

    // Immediate shifts present only the shift amount as operand b, so the
    // arithmetic qualifier in instr[30] never leaks into the shift count.
    assign shamt_ext = XLEN'(instr[20 +: SHW]);

    // Bits above the shift amount, excluding the instr[30] qualifier, must be
    // zero for an immediate shift to be legal.
    assign shift_hi_zero = ~instr[31] & (instr[29:20+SHW] == '0);

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    bundle_t dec;
    logic    legal;

    // Decode the input word into an operand bundle; illegal encodings
    // collapse to an all-zero bundle with only rd and the illegal flag set.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        dec    = '0;
        legal  = 1'b0;
        dec.rd = rd_f;

        case (opcode)
            OPC_OP: begin
                legal   = (funct7 == F7_BASE) ||
                          ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
                dec.a   = rs1_val;
                dec.b   = rs2_val;
                dec.op  = funct3;
                dec.sub = instr[30] & (funct3 == F3_ADD);
                dec.sra = instr[30] & (funct3 == F3_SR);
            end

            OPC_OP_IMM: begin
                case (funct3)
                    F3_SLL:  legal = shift_hi_zero & ~instr[30];
                    F3_SR:   legal = shift_hi_zero;
                    default: legal = 1'b1;
                endcase
                dec.a   = rs1_val;
                dec.b   = ((funct3 == F3_SLL) || (funct3 == F3_SR)) ? shamt_ext : i_imm_ext;
                dec.op  = funct3;
                dec.sra = instr[30] & (funct3 == F3_SR);
            end

            OPC_LUI: begin
                legal = 1'b1;
                dec.b = u_imm_ext;
            end

            OPC_AUIPC: begin
                legal = 1'b1;
                dec.a = pc;
                dec.b = u_imm_ext;
            end

            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec.a   = '0;
            dec.b   = '0;
            dec.op  = 3'b000;
            dec.sub = 1'b0;
            dec.sra = 1'b0;
        end

        dec.illegal = ~legal;
        dec.wen     = legal & (rd_f != 5'd0);
    end

    // ------------------------------------------------------------------
    // Two-entry buffer: main drives the outputs, skid absorbs one extra
    // transfer accepted while main is stalled.
    // ------------------------------------------------------------------
    bundle_t main_q;
    bundle_t skid_q;
    logic    main_valid;
    logic    skid_valid;

    logic    in_fire;
    logic    out_fire;
    logic    to_main;
    logic    to_skid;
    logic    skid_to_main;

    assign in_fire      = in_valid & ~skid_valid;
    assign out_fire     = main_valid & out_ready;

    // The input lands in main when main is empty or leaving this cycle; the
    // skid is necessarily empty whenever the input is accepted.
    assign to_main      = in_fire & (~main_valid | out_fire);
    assign to_skid      = in_fire & main_valid & ~out_fire;
    assign skid_to_main = out_fire & skid_valid;

    // Main payload and both occupancy flags; reset empties the buffer and
    // zeroes the visible bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop see pre-edge values.
            if (skid_to_main) begin
                main_q <= skid_q;
            end else if (to_main) begin
                main_q <= dec;
            end

            if (skid_to_main || to_main) begin
                main_valid <= 1'b1;
            end else if (out_fire) begin
                main_valid <= 1'b0;
            end

            if (to_skid) begin
                skid_valid <= 1'b1;
            end else if (skid_to_main) begin
                skid_valid <= 1'b0;
            end
        end
    end

    // Skid payload capture.
    always_ff @(posedge clk) begin
        // NOTE: payload left unreset; skid_valid alone says whether it means anything.
        if (to_skid) begin
            skid_q <= dec;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign a         = main_q.a;
    assign b         = main_q.b;
    assign op        = main_q.op;
    assign sub       = main_q.sub;
    assign sra       = main_q.sra;
    assign rd        = main_q.rd;
    assign wen       = main_q.wen;
    assign illegal   = main_q.illegal;

endmodule
